sts2stl: RTL and testbench

STS2STL -- requirements
Module: sts2stl

---
 rtl/sts2stl.sv | 102 ++++++++++
 tb/tb_sts2stl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sts2stl.sv
// rtl/sts2stl.sv - packs a 16-bit packet stream into 32-bit words
module sts2stl #(
    parameter int FIRST_HIGH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in_data,
    input  logic        data_in_valid,
    output logic        data_in_ready,
    input  logic        data_in_empty,
    input  logic        data_in_startofpacket,
    input  logic        data_in_endofpacket,
    output logic [31:0] data_out_data,
    output logic        data_out_valid,
    input  logic        data_out_ready,
    output logic [1:0]  data_out_empty,
    output logic        data_out_startofpacket,
    output logic        data_out_endofpacket,
    output logic        pkt_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH
    } state_t;

    state_t      state;
    logic [15:0] hold_data;
    logic        hold_sop;
    logic        accept;
    logic        drain;

    // Ready is a function of the output register only, so it is 1 whenever the word slot is free.
    assign data_in_ready = rst || !data_out_valid || data_out_ready;
    assign accept        = data_in_valid && data_in_ready;
    assign drain         = data_out_valid && data_out_ready;

    function automatic logic [31:0] pack_word(input logic [15:0] first, input logic [15:0] second);
        return (FIRST_HIGH != 0) ? {first, second} : {second, first};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= S_IDLE;
            hold_data              <= 16'h0000;
            hold_sop               <= 1'b0;
            data_out_data          <= 32'h0000_0000;
            data_out_valid         <= 1'b0;
            data_out_empty         <= 2'd0;
            data_out_startofpacket <= 1'b0;
            data_out_endofpacket   <= 1'b0;
            pkt_error              <= 1'b0;
        end else begin
            pkt_error <= 1'b0;

            if (drain) begin
                data_out_valid         <= 1'b0;
                data_out_data          <= 32'h0000_0000;
                data_out_empty         <= 2'd0;
                data_out_startofpacket <= 1'b0;
                data_out_endofpacket   <= 1'b0;
            end

            // A load in the same cycle overrides the drain clear above.
            if (accept) begin
                if (state == S_HIGH && !data_in_startofpacket) begin
                    data_out_data          <= pack_word(hold_data, data_in_data);
                    data_out_valid         <= 1'b1;
                    data_out_startofpacket <= hold_sop;
                    data_out_endofpacket   <= data_in_endofpacket;
                    data_out_empty         <= data_in_endofpacket ? {1'b0, data_in_empty} : 2'd0;
                    hold_data              <= 16'h0000;
                    hold_sop               <= 1'b0;
                    state                  <= data_in_endofpacket ? S_IDLE : S_LOW;
                end else if (state == S_IDLE && !data_in_startofpacket) begin
                    pkt_error <= 1'b1;
                end else begin
                    // SOP inside a packet abandons the old one (and any held half).
                    if (data_in_startofpacket && state != S_IDLE) begin
                        pkt_error <= 1'b1;
                    end
                    if (data_in_endofpacket) begin
                        data_out_data          <= pack_word(data_in_data, 16'h0000);
                        data_out_valid         <= 1'b1;
                        data_out_startofpacket <= data_in_startofpacket;
                        data_out_endofpacket   <= 1'b1;
                        data_out_empty         <= {1'b1, data_in_empty};
                        hold_data              <= 16'h0000;
                        hold_sop               <= 1'b0;
                        state                  <= S_IDLE;
                    end else begin
                        hold_data <= data_in_data;
                        hold_sop  <= data_in_startofpacket;
                        state     <= S_HIGH;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sts2stl.sv
// tb/tb_sts2stl.sv - directed self-checking bench for sts2stl
module tb_sts2stl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in_data;
    logic        data_in_valid;
    logic        data_in_empty;
    logic        data_in_startofpacket;
    logic        data_in_endofpacket;
    logic        data_out_ready;

    logic        data_in_ready;
    logic [31:0] data_out_data;
    logic        data_out_valid;
    logic [1:0]  data_out_empty;
    logic        data_out_startofpacket;
    logic        data_out_endofpacket;
    logic        pkt_error;

    logic        lo_in_ready;
    logic [31:0] lo_data;
    logic        lo_valid;
    logic [1:0]  lo_empty;
    logic        lo_sop;
    logic        lo_eop;
    logic        lo_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [35:0] mon_q[$];
    logic [35:0] rec;

    always #5 clk = ~clk;

    sts2stl #(.FIRST_HIGH(1)) dut (
        .clk(clk), .rst(rst),
        .data_in_data(data_in_data), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .data_in_empty(data_in_empty), .data_in_startofpacket(data_in_startofpacket),
        .data_in_endofpacket(data_in_endofpacket),
        .data_out_data(data_out_data), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .data_out_empty(data_out_empty), .data_out_startofpacket(data_out_startofpacket),
        .data_out_endofpacket(data_out_endofpacket), .pkt_error(pkt_error)
    );

    sts2stl #(.FIRST_HIGH(0)) dut_lo (
        .clk(clk), .rst(rst),
        .data_in_data(data_in_data), .data_in_valid(data_in_valid), .data_in_ready(lo_in_ready),
        .data_in_empty(data_in_empty), .data_in_startofpacket(data_in_startofpacket),
        .data_in_endofpacket(data_in_endofpacket),
        .data_out_data(lo_data), .data_out_valid(lo_valid), .data_out_ready(data_out_ready),
        .data_out_empty(lo_empty), .data_out_startofpacket(lo_sop),
        .data_out_endofpacket(lo_eop), .pkt_error(lo_err)
    );

    // Record every output transfer; sampled on the falling edge ahead of the transferring rising edge.
    always @(negedge clk) begin
        if (!rst && data_out_valid && data_out_ready)
            mon_q.push_back({data_out_endofpacket, data_out_startofpacket, data_out_empty, data_out_data});
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_empty,
                              input logic exp_sop, input logic exp_eop);
        check_eq({tag, ".valid"}, {31'd0, data_out_valid}, 32'd1);
        check_eq({tag, ".data"},  data_out_data, exp_data);
        check_eq({tag, ".empty"}, {30'd0, data_out_empty}, {30'd0, exp_empty});
        check_eq({tag, ".sop"},   {31'd0, data_out_startofpacket}, {31'd0, exp_sop});
        check_eq({tag, ".eop"},   {31'd0, data_out_endofpacket}, {31'd0, exp_eop});
    endtask

    task automatic send(input logic [15:0] d, input logic sop, input logic eop, input logic emp);
        data_in_data          = d;
        data_in_startofpacket = sop;
        data_in_endofpacket   = eop;
        data_in_empty         = emp;
        data_in_valid         = 1'b1;
        @(posedge clk);
        #1;
        data_in_valid         = 1'b0;
        data_in_startofpacket = 1'b0;
        data_in_endofpacket   = 1'b0;
        data_in_empty         = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        data_in_data = 16'h0; data_in_valid = 1'b0; data_in_empty = 1'b0;
        data_in_startofpacket = 1'b0; data_in_endofpacket = 1'b0;
        data_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.valid", {31'd0, data_out_valid}, 32'd0);
        check_eq("rst.data", data_out_data, 32'h0);
        check_eq("rst.err", {31'd0, pkt_error}, 32'd0);
        check_eq("rst.in_ready", {31'd0, data_in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst.in_ready", {31'd0, data_in_ready}, 32'd1);

        // Even packet, back-to-back beats
        send(16'h0001, 1, 0, 0);
        check_eq("even.b0.valid", {31'd0, data_out_valid}, 32'd0);
        send(16'h0002, 0, 0, 0);
        check_word("even.w0", 32'h0001_0002, 2'd0, 1, 0);
        check_eq("even.lo.w0", lo_data, 32'h0002_0001);
        send(16'h0003, 0, 0, 0);
        check_eq("even.b2.valid", {31'd0, data_out_valid}, 32'd0);
        send(16'h0004, 0, 1, 0);
        check_word("even.w1", 32'h0003_0004, 2'd0, 0, 1);

        // Odd packet
        send(16'h0001, 1, 0, 0);
        check_eq("odd.b0.valid", {31'd0, data_out_valid}, 32'd0);
        send(16'h0002, 0, 0, 0);
        check_word("odd.w0", 32'h0001_0002, 2'd0, 1, 0);
        send(16'h0003, 0, 1, 1);
        check_word("odd.w1", 32'h0003_0000, 2'd3, 0, 1);

        // Single-beat packet, both lane orders
        send(16'hABCD, 1, 1, 0);
        check_word("single", 32'hABCD_0000, 2'd2, 1, 1);
        check_eq("single.lo.data", lo_data, 32'h0000_ABCD);
        check_eq("single.lo.empty", {30'd0, lo_empty}, 32'd2);
        @(posedge clk);
        #1;
        check_eq("idle.valid", {31'd0, data_out_valid}, 32'd0);
        check_eq("idle.flags", {29'd0, data_out_empty, data_out_endofpacket}, 32'd0);

        // Backpressure
        mon_q.delete();
        data_out_ready = 1'b0;
        send(16'h0011, 1, 0, 0);
        send(16'h0022, 0, 0, 0);
        check_word("bp.w0", 32'h0011_0022, 2'd0, 1, 0);
        data_in_data = 16'h0033; data_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("bp.stall%0d.in_ready", i), {31'd0, data_in_ready}, 32'd0);
            check_eq($sformatf("bp.stall%0d.data", i), data_out_data, 32'h0011_0022);
        end
        data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        check_eq("bp.drained.valid", {31'd0, data_out_valid}, 32'd0);
        send(16'h0044, 0, 1, 0);
        check_word("bp.w1", 32'h0033_0044, 2'd0, 0, 1);
        @(posedge clk);
        #1;
        check_eq("bp.count", mon_q.size(), 32'd2);
        if (mon_q.size() == 2) begin
            rec = mon_q[0];
            check_eq("bp.q0", rec[31:0], 32'h0011_0022);
            rec = mon_q[1];
            check_eq("bp.q1", rec[31:0], 32'h0033_0044);
        end

        // Protocol errors
        send(16'h0055, 0, 0, 0);
        check_eq("err.nosop.err", {31'd0, pkt_error}, 32'd1);
        check_eq("err.nosop.valid", {31'd0, data_out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("err.pulse_end", {31'd0, pkt_error}, 32'd0);
        send(16'h0066, 1, 0, 0);
        send(16'h0077, 1, 0, 0);
        check_eq("err.high_sop.err", {31'd0, pkt_error}, 32'd1);
        check_eq("err.high_sop.valid", {31'd0, data_out_valid}, 32'd0);
        send(16'h0088, 0, 1, 0);
        check_eq("err.recover.err", {31'd0, pkt_error}, 32'd0);
        check_word("err.recover", 32'h0077_0088, 2'd0, 1, 1);
        send(16'h0001, 1, 0, 0);
        send(16'h0002, 0, 0, 0);
        send(16'h0003, 1, 0, 0);
        check_eq("err.low_sop.err", {31'd0, pkt_error}, 32'd1);
        send(16'h0004, 0, 1, 0);
        check_word("err.low_sop", 32'h0003_0004, 2'd0, 1, 1);

        // Reset with a pending word
        data_out_ready = 1'b0;
        send(16'h000A, 1, 0, 0);
        send(16'h000B, 0, 0, 0);
        check_eq("rstmid.pending", {31'd0, data_out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rstmid.in_ready_during", {31'd0, data_in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("rstmid.valid", {31'd0, data_out_valid}, 32'd0);
        check_eq("rstmid.data", data_out_data, 32'h0);
        check_eq("rstmid.flags", {28'd0, data_out_empty, data_out_startofpacket, data_out_endofpacket}, 32'd0);
        rst = 1'b0;
        data_out_ready = 1'b1;

        // Reset while half held: the next non-SOP beat must be treated as outside a packet
        send(16'h0009, 1, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(16'h0005, 0, 1, 0);
        check_eq("rsthigh.err", {31'd0, pkt_error}, 32'd1);
        check_eq("rsthigh.valid", {31'd0, data_out_valid}, 32'd0);
        send(16'h000C, 1, 0, 0);
        send(16'h000D, 0, 1, 0);
        check_word("rsthigh.after", 32'h000C_000D, 2'd0, 1, 1);

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
